mem_stage_waitstate: RTL and testbench
======================================

Name: mem_stage_waitstate

Overview:
- Parametrised successor to the single-cycle data-memory stage of the 5-stage ARM pipeline.
- Models a data memory with a configurable number of wait states.
- Drives a freeze signal that stalls the whole pipeline while an access is in progress.
- Sits between the EXE/MEM pipeline register and the MEM/WB register. Adds byte-address translation, range/alignment checking and multi-cycle handshaking.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8 and a power of two.
- DEPTH, 64, number of words in the memory array.
- ADDR_W, 32, width of the byte address from the ALU.
- BASE_ADDR, 1024, byte address mapped to word 0.
- WAIT_CYCLES, 3, extra cycles per access; 0 is legal.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- MEM_R_EN  in  1  read request from EXE/MEM register
- MEM_W_EN  in  1  write request from EXE/MEM register
- ALU_res  in  ADDR_W  byte address
- ST_val  in  DATA_W  store data
- mem_out  out  DATA_W  read data, registered
- freeze  out  1  pipeline stall; combinational
- busy  out  1  high in WAIT or DONE state
- err  out  1  one-cycle pulse: access was out of range or misaligned

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, mem_out=0, err=0, busy=0, freeze=0.
  - Memory array contents are not reset.
  - Captured request registers are cleared.
- Word index = (ALU_res - BASE_ADDR) >> log2(DATA_W/8), computed in ADDR_W-bit unsigned arithmetic.
  - In range iff ALU_res >= BASE_ADDR and index < DEPTH.
  - Misaligned iff the low log2(DATA_W/8) address bits are nonzero.
- req = MEM_R_EN | MEM_W_EN. If both are high, the access is treated as a write.
- States:
  - IDLE:
    - If req, capture address, ST_val and kind (read/write).
    - Load counter with WAIT_CYCLES.
    - Go to WAIT if WAIT_CYCLES > 0, else DONE.
    - freeze = req (combinational).
  - WAIT:
    - Counter decrements each cycle; go to DONE when counter reaches 1.
    - freeze = 1. Live inputs are ignored; captured values are used.
  - DONE:
    - Exactly one cycle. freeze = 0, so the pipeline advances this cycle. Next state IDLE.
    - On entry to DONE, i.e. at the clock edge that moves the FSM into DONE:
      - Write: memory[index] <= captured data, only if in range and aligned.
      - Read: mem_out <= memory[index] if legal, else 0.
      - err <= 1 if illegal.
    - err returns to 0 on the following edge.
- Latency:
  - freeze is high for exactly WAIT_CYCLES+1 consecutive cycles per access, starting in the request's first cycle.
  - mem_out is valid from the DONE cycle and holds until the next read completes. Writes do not change mem_out.
- No request in IDLE: freeze=0, state stays IDLE, nothing changes.
- Request deasserted or changed during WAIT: no effect. The captured access still completes.
- Back-to-back accesses: a request present in the DONE cycle is not accepted. The pipeline advances in DONE, and the next instruction's request is accepted in the following IDLE cycle.
- Reset during WAIT: the access is abandoned and no memory write occurs. On reset release the state is IDLE.
- Illegal writes never modify any memory location.

Test Plan:
- Write then read, WAIT_CYCLES=3:
  - Write ALU_res=1028, ST_val=0xDEADBEEF -> freeze high 4 cycles then low 1 cycle; busy high 4 cycles.
  - Then read 1028 -> freeze high 4 cycles; mem_out=0xDEADBEEF in the DONE cycle; err=0.
- WAIT_CYCLES=0, read of a location holding 0x12345678 -> freeze high exactly 1 cycle; mem_out=0x12345678 the next cycle.
- Out of range, WAIT_CYCLES=3:
  - Write ALU_res=1020 -> err pulses 1 cycle in DONE; no location changes.
  - Read of 1024+4*DEPTH -> mem_out=0, err pulses.
  - Misaligned read 1030 -> mem_out=0, err pulses.
- Request dropped mid-wait: start write 1032=0x55 with WAIT_CYCLES=3, drop MEM_W_EN after 1 cycle -> freeze still lasts 4 cycles; a later read of 1032 returns 0x55.
- Reset mid-wait: assert rst=0 in the second WAIT cycle of a write of 0xAA to 1036 -> freeze=0 and mem_out=0 immediately; a later read of 1036 returns the prior value, not 0xAA.
- Simultaneous enables and back-to-back:
  - MEM_R_EN=MEM_W_EN=1 at 1040 with 0x77 -> a write occurs and mem_out is unchanged.
  - A read request held through DONE is accepted only in the next IDLE cycle: two full freeze windows separated by exactly one freeze=0 cycle.

Source files
------------

// File: rtl/mem_stage_waitstate.sv
`timescale 1ns/1ps
// Data-memory stage with WAIT_CYCLES wait states: freeze stalls the pipeline for WAIT_CYCLES+1 cycles per access,
// result lands in the one-cycle DONE state; requests seen in WAIT/DONE are ignored (the pipeline is held by freeze).
module mem_stage_waitstate #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 32,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [ADDR_W-1:0] ALU_res,
  input  logic [DATA_W-1:0] ST_val,
  output logic [DATA_W-1:0] mem_out,
  output logic              freeze,
  output logic              busy,
  output logic              err
);

  localparam int SH    = $clog2(DATA_W / 8);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << SH) - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] mem_out_q, mem_out_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              req;
  logic              enter_done;
  logic [ADDR_W-1:0] acc_addr;
  logic [ADDR_W-1:0] acc_off;
  logic [ADDR_W-1:0] acc_idx;
  logic [DATA_W-1:0] acc_data;
  logic              acc_wr;
  logic              acc_legal;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;

  assign req     = MEM_R_EN | MEM_W_EN;
  assign mem_out = mem_out_q;
  assign err     = err_q;

  // With zero wait states the access completes on the accepting edge, so live inputs feed it directly.
  always_comb begin
    acc_addr = addr_q;
    acc_data = data_q;
    acc_wr   = wr_q;
    if (state_q == S_IDLE) begin
      acc_addr = ALU_res;
      acc_data = ST_val;
      acc_wr   = MEM_W_EN;
    end
    acc_off   = acc_addr - BASE;
    acc_idx   = acc_off >> SH;
    acc_legal = (acc_addr >= BASE) && (acc_idx < DEPTH_A) && ((acc_addr & ALIGN_MASK) == '0);
    mem_idx   = acc_idx[IDX_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = wr_q;
    freeze     = 1'b0;
    busy       = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        freeze = req;
        if (req) begin
          addr_d = ALU_res;
          data_d = ST_val;
          wr_d   = MEM_W_EN;
          cnt_d  = CNT_LOAD;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end
        end
      end
      S_WAIT: begin
        freeze = 1'b1;
        busy   = 1'b1;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A held request must not stall the pipeline while reset is asserted.
    if (!rst) freeze = 1'b0;
  end

  always_comb begin
    mem_out_d = mem_out_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    if (enter_done) begin
      err_d = !acc_legal;
      if (acc_wr) begin
        mem_we = acc_legal;
      end else begin
        mem_out_d = acc_legal ? mem_q[mem_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      mem_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      mem_out_q <= mem_out_d;
      err_q     <= err_d;
    end
  end

  // Array contents survive reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      mem_q[mem_idx] <= acc_data;
    end
  end

endmodule

// File: tb/tb_mem_stage_waitstate.sv
`timescale 1ns/1ps
// Scoreboarded bench: a word-array reference model predicts each access, a negedge monitor checks every DONE cycle;
// a second zero-wait-state instance is exercised with a short directed sequence.
module tb_mem_stage_waitstate;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 32;
  localparam int BASE  = 1024;
  localparam int WC    = 3;

  logic          clk = 1'b0;
  logic          rst, rst0;
  logic          r_en, w_en;
  logic [AW-1:0] alu;
  logic [DW-1:0] stv, mem_out;
  logic          freeze, busy, err;
  logic          r0, w0;
  logic [AW-1:0] alu0;
  logic [DW-1:0] stv0, mem_out0;
  logic          freeze0, busy0, err0;

  always #5 clk = ~clk;

  mem_stage_waitstate #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .ALU_res(alu), .ST_val(stv),
    .mem_out(mem_out), .freeze(freeze), .busy(busy), .err(err));

  mem_stage_waitstate #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst0), .MEM_R_EN(r0), .MEM_W_EN(w0), .ALU_res(alu0), .ST_val(stv0),
    .mem_out(mem_out0), .freeze(freeze0), .busy(busy0), .err(err0));

  typedef struct {
    logic [DW-1:0] out;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_out = '0;
  bit            prev_hold = 1'b0;
  bit            done0     = 1'b0;
  int            fz_run    = 0;
  int            bz_run    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_legal(input logic [31:0] a);
    return (a >= 32'(BASE)) && ((a - 32'(BASE)) / 4 < 32'(DEPTH)) && (a % 4 == 0);
  endfunction

  // Reference: a write stores the word if legal; a read replaces the output latch with the word or zero.
  task automatic model_issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   ok;
    ok = addr_legal(a);
    if (wr) begin
      if (ok) model_mem[(a - 32'(BASE)) / 4] = d;
    end else begin
      model_out = ok ? model_mem[(a - 32'(BASE)) / 4] : 32'h0;
    end
    e.out = model_out;
    e.err = !ok;
    exp_q.push_back(e);
  endtask

  // mode 0 keeps the request steady, 1 drops the enables after the first cycle, 2 drives garbage during WAIT.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int mode, input bit hold);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    r_en = rd; w_en = wr; alu = a; stv = d;
    model_issue(wr, a, d);
    if (prev_hold) chk("b2b_accept_freeze", 32'(freeze), 32'd1);
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      if (busy && !freeze) begin
        done = 1'b1;
      end else if (mode == 1) begin
        r_en = 1'b0; w_en = 1'b0;
      end else if (mode == 2) begin
        r_en = 1'($urandom_range(1)); w_en = 1'($urandom_range(1));
        alu  = $urandom; stv = $urandom;
      end
    end
    if (!done) chk("access_done_timeout", 32'(done), 32'd1);
    if (!hold) begin r_en = 1'b0; w_en = 1'b0; end
    prev_hold = hold;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      fz_run = 0;
      bz_run = 0;
    end else begin
      if (busy) bz_run++; else bz_run = 0;
      if (busy && !freeze) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mem_out", mem_out, mon_e.out);
          chk("err", 32'(err), 32'(mon_e.err));
          chk("freeze_len", 32'(fz_run), 32'(WC + 1));
          chk("busy_len", 32'(bz_run), 32'(WC + 1));
        end
        fz_run = 0;
      end else begin
        if (freeze) fz_run++; else fz_run = 0;
        if (err) chk("err_outside_done", 32'(err), 32'd0);
      end
    end
  end

  // Zero-wait-state instance: one-cycle freeze, result visible in the very next cycle.
  initial begin
    r0 = 1'b0; w0 = 1'b0; alu0 = '0; stv0 = '0;
    wait (rst0 === 1'b1);
    @(posedge clk); #1; w0 = 1'b1; alu0 = 32'd1048; stv0 = 32'h12345678;
    @(negedge clk); chk("w0_wr_freeze", 32'(freeze0), 32'd1);
    @(posedge clk); #1; w0 = 1'b0;
    @(negedge clk);
    chk("w0_wr_done_freeze", 32'(freeze0), 32'd0);
    chk("w0_wr_done_busy", 32'(busy0), 32'd1);
    chk("w0_wr_mem_out", mem_out0, 32'h0);
    @(posedge clk); #1; r0 = 1'b1; alu0 = 32'd1048;
    @(negedge clk); chk("w0_rd_freeze", 32'(freeze0), 32'd1);
    @(posedge clk); #1; r0 = 1'b0;
    @(negedge clk);
    chk("w0_rd_done_freeze", 32'(freeze0), 32'd0);
    chk("w0_rd_mem_out", mem_out0, 32'h12345678);
    chk("w0_rd_err", 32'(err0), 32'd0);
    @(posedge clk); #1; r0 = 1'b1; alu0 = 32'd1029;
    @(posedge clk); #1; r0 = 1'b0;
    @(negedge clk);
    chk("w0_misalign_mem_out", mem_out0, 32'h0);
    chk("w0_misalign_err", 32'(err0), 32'd1);
    @(negedge clk);
    chk("w0_err_pulse_end", 32'(err0), 32'd0);
    chk("w0_idle_busy", 32'(busy0), 32'd0);
    done0 = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rst0 = 1'b0;
    r_en = 1'b0; w_en = 1'b0; alu = '0; stv = '0;
    repeat (3) @(posedge clk);
    #1;
    r_en = 1'b1;
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_mem_out", mem_out, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst0_mem_out", mem_out0, 32'h0);
    r_en = 1'b0;
    @(negedge clk); #1; rst = 1'b1; rst0 = 1'b1;

    for (int i = 0; i < DEPTH; i++) do_access(1'b0, 1'b1, 32'(BASE + 4 * i), $urandom, 0, 1'b0);

    do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 0, 1'b0);
    do_access(1'b0, 1'b1, 32'd1020, 32'h11111111, 0, 1'b0);
    do_access(1'b1, 1'b0, 32'(BASE + 4 * DEPTH), 32'h0, 0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1030, 32'h0, 0, 1'b0);
    do_access(1'b0, 1'b1, 32'd1026, 32'h22222222, 0, 1'b0);
    do_access(1'b0, 1'b1, 32'd1032, 32'h55, 1, 1'b0);
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, 0, 1'b0);
    do_access(1'b1, 1'b1, 32'd1040, 32'h77, 0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1040, 32'h0, 0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1044, 32'h0, 0, 1'b1);
    do_access(1'b1, 1'b0, 32'd1044, 32'h0, 0, 1'b0);

    // Reset in the second WAIT cycle of a write abandons it; the request is still held by the pipeline.
    @(posedge clk); #1; w_en = 1'b1; alu = 32'd1036; stv = 32'hAA;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midwait_rst_freeze", 32'(freeze), 32'd0);
    chk("midwait_rst_mem_out", mem_out, 32'h0);
    chk("midwait_rst_busy", 32'(busy), 32'd0);
    model_out = '0;
    w_en = 1'b0;
    @(negedge clk); #1; rst = 1'b1;
    do_access(1'b1, 1'b0, 32'd1036, 32'h0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, d;
      logic        rd, wr;
      int          mode, kind;
      bit          hold;
      a = 32'(BASE) + 32'(4 * $urandom_range(DEPTH - 1));
      case ($urandom_range(9))
        0: a = a + 32'($urandom_range(3, 1));
        1: a = 32'(BASE) - 32'(4 * $urandom_range(8, 1));
        2: a = 32'(BASE + 4 * DEPTH) + 32'(4 * $urandom_range(7));
        default: ;
      endcase
      kind = int'($urandom_range(2));
      rd   = (kind != 1);
      wr   = (kind != 0);
      d    = $urandom;
      mode = int'($urandom_range(2));
      hold = (mode == 0) && ($urandom_range(3) == 0);
      repeat ($urandom_range(2)) @(posedge clk);
      do_access(rd, wr, a, d, mode, hold);
      if (hold) do_access(rd, wr, a, d, 0, 1'b0);
    end

    for (int i = 0; i < DEPTH; i++) do_access(1'b1, 1'b0, 32'(BASE + 4 * i), 32'h0, 0, 1'b0);

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 100 && !done0; i++) @(posedge clk);
    chk("w0_sequence_done", 32'(done0), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
